instr_queue: RTL and testbench

Dual-entry-per-cycle instruction queue sitting directly downstream of the instruction fetcher and upstream of the decode/issue stage. It accepts up to two fetched instructions (slot A, then slot B) per cycle with their PCs, holds them in a circular buffer, and presents the two oldest entries to decode. It produces the fetcher's `stall` input as back-pressure and discards its contents on a pipeline flush (branch taken).

---
 rtl/instr_queue_if.sv | 36 +++
 rtl/instr_queue.sv | 87 ++++++++
 tb/tb_instr_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/instr_queue_if.sv
// Fetcher/decode handshake bundle for instr_queue.
//   flush      : discard all queued entries (branch redirect)
//   in_a/in_b  : up to two fetched instructions per cycle, A older than B
//   stall      : back-pressure to the fetcher; pushes ignored while high
//   out_a/out_b: oldest and second-oldest queued entries
//   pop_count  : entries consumed by decode this cycle
// slave is the queue's view; master is the fetcher/decode side.
interface instr_queue_if;
  logic        flush;
  logic        in_a_valid;
  logic [31:0] in_a_instr;
  logic [31:0] in_a_addr;
  logic        in_b_valid;
  logic [31:0] in_b_instr;
  logic [31:0] in_b_addr;
  logic        stall;
  logic        out_a_valid;
  logic [31:0] out_a_instr;
  logic [31:0] out_a_addr;
  logic        out_b_valid;
  logic [31:0] out_b_instr;
  logic [31:0] out_b_addr;
  logic [1:0]  pop_count;

  modport slave (
    input  flush, in_a_valid, in_a_instr, in_a_addr, in_b_valid, in_b_instr, in_b_addr,
           pop_count,
    output stall, out_a_valid, out_a_instr, out_a_addr, out_b_valid, out_b_instr, out_b_addr
  );

  modport master (
    output flush, in_a_valid, in_a_instr, in_a_addr, in_b_valid, in_b_instr, in_b_addr,
           pop_count,
    input  stall, out_a_valid, out_a_instr, out_a_addr, out_b_valid, out_b_instr, out_b_addr
  );
endinterface

// File: rtl/instr_queue.sv
// Dual-entry-per-cycle instruction queue between fetch and decode.
// Circular buffer of DEPTH {addr, instr} entries; accepts up to two pushes
// and up to two pops per cycle, and presents the two oldest entries.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high; clears pointers and count
//   q     : instr_queue_if.slave (fetch inputs, stall, decode outputs, pop_count)
module instr_queue #(
  parameter int unsigned DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  instr_queue_if.slave  q
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [63:0]     mem [DEPTH];
  logic [PtrW-1:0] rdPtrQ, rdPtrD;
  logic [PtrW-1:0] wrPtrQ, wrPtrD;
  logic [CntW-1:0] countQ, countD;
  logic [CntW-1:0] freeSlots;
  logic [PtrW-1:0] wrIdxB;
  logic [PtrW-1:0] rdIdxB;
  logic [1:0]      pushN;
  logic [1:0]      popReq;
  logic [1:0]      popEff;
  logic            pushEn;

  // Stall only looks at registered count so the fetcher sees a stable signal.
  assign freeSlots = CntW'(DEPTH) - countQ;
  assign q.stall   = freeSlots < CntW'(2);
  assign pushEn    = !q.stall && !q.flush;

  assign pushN  = {1'b0, q.in_a_valid} + {1'b0, q.in_b_valid};
  assign popReq = (q.pop_count == 2'd3) ? 2'd2 : q.pop_count;
  // When count < popReq (<= 2) count fits in two bits, so the slice is exact.
  assign popEff = (CntW'(popReq) > countQ) ? countQ[1:0] : popReq;

  // A B-only push (misaligned branch target) lands B at the write pointer.
  assign wrIdxB = q.in_a_valid ? (wrPtrQ + PtrW'(1)) : wrPtrQ;
  assign rdIdxB = rdPtrQ + PtrW'(1);

  always_comb begin
    rdPtrD = rdPtrQ + PtrW'(popEff);
    wrPtrD = wrPtrQ;
    countD = countQ - CntW'(popEff);
    if (pushEn) begin
      wrPtrD = wrPtrQ + PtrW'(pushN);
      countD = countQ + CntW'(pushN) - CntW'(popEff);
    end
    if (q.flush) begin
      rdPtrD = '0;
      wrPtrD = '0;
      countD = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtrQ <= '0;
      wrPtrQ <= '0;
      countQ <= '0;
    end else begin
      rdPtrQ <= rdPtrD;
      wrPtrQ <= wrPtrD;
      countQ <= countD;
    end
  end

  // Storage is not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (!reset && pushEn) begin
      if (q.in_a_valid) mem[wrPtrQ] <= {q.in_a_addr, q.in_a_instr};
      if (q.in_b_valid) mem[wrIdxB] <= {q.in_b_addr, q.in_b_instr};
    end
  end

  assign q.out_a_valid = countQ >= CntW'(1);
  assign q.out_b_valid = countQ >= CntW'(2);
  assign q.out_a_instr = mem[rdPtrQ][31:0];
  assign q.out_a_addr  = mem[rdPtrQ][63:32];
  assign q.out_b_instr = mem[rdIdxB][31:0];
  assign q.out_b_addr  = mem[rdIdxB][63:32];

endmodule

// File: tb/tb_instr_queue.sv
module tb_instr_queue;

  logic clk = 1'b0;
  logic reset;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  instr_queue_if qi ();

  instr_queue #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (qi.slave)
  );

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [31:0] ai, input logic [31:0] aa,
                       input logic bv, input logic [31:0] bi, input logic [31:0] ba,
                       input logic [1:0] pc, input logic fl);
    qi.in_a_valid = av;
    qi.in_a_instr = ai;
    qi.in_a_addr  = aa;
    qi.in_b_valid = bv;
    qi.in_b_instr = bi;
    qi.in_b_addr  = ba;
    qi.pop_count  = pc;
    qi.flush      = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd0, 1'b0);
  endtask

  // Advance one edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic [31:0] ai, input logic [31:0] aa,
                          input logic [31:0] bi, input logic [31:0] ba);
    checkEq({tag, "_a_valid"}, 64'(qi.out_a_valid), 64'd1);
    checkEq({tag, "_a_instr"}, 64'(qi.out_a_instr), 64'(ai));
    checkEq({tag, "_a_addr"},  64'(qi.out_a_addr),  64'(aa));
    checkEq({tag, "_b_valid"}, 64'(qi.out_b_valid), 64'd1);
    checkEq({tag, "_b_instr"}, 64'(qi.out_b_instr), 64'(bi));
    checkEq({tag, "_b_addr"},  64'(qi.out_b_addr),  64'(ba));
  endtask

  task automatic checkEmpty(input string tag);
    checkEq({tag, "_count"},   64'(dut.countQ),     64'd0);
    checkEq({tag, "_a_valid"}, 64'(qi.out_a_valid), 64'd0);
    checkEq({tag, "_b_valid"}, 64'(qi.out_b_valid), 64'd0);
    checkEq({tag, "_stall"},   64'(qi.stall),       64'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    checkEmpty("reset");

    // First pair: items 0,1 (instr = i*0x11111111, addr = 4*i).
    drive(1'b1, 32'h00000000, 32'h0, 1'b1, 32'h11111111, 32'h4, 2'd0, 1'b0);
    step();
    checkOut("push1", 32'h00000000, 32'h0, 32'h11111111, 32'h4);
    checkEq("push1_count", 64'(dut.countQ), 64'd2);
    checkEq("push1_stall", 64'(qi.stall), 64'd0);

    drive(1'b1, 32'h22222222, 32'h8, 1'b1, 32'h33333333, 32'hC, 2'd0, 1'b0);
    step();
    checkEq("push2_count", 64'(dut.countQ), 64'd4);
    drive(1'b1, 32'h44444444, 32'h10, 1'b1, 32'h55555555, 32'h14, 2'd0, 1'b0);
    step();
    checkEq("push3_count", 64'(dut.countQ), 64'd6);
    checkEq("push3_stall", 64'(qi.stall), 64'd0);
    drive(1'b1, 32'h66666666, 32'h18, 1'b1, 32'h77777777, 32'h1C, 2'd0, 1'b0);
    step();
    checkEq("push4_count", 64'(dut.countQ), 64'd8);
    checkEq("push4_stall", 64'(qi.stall), 64'd1);
    // Ignored while stalled.
    drive(1'b1, 32'hAAAAAAAA, 32'h20, 1'b1, 32'hBBBBBBBB, 32'h24, 2'd0, 1'b0);
    step();
    checkEq("push5_count", 64'(dut.countQ), 64'd8);
    checkOut("full", 32'h00000000, 32'h0, 32'h11111111, 32'h4);

    // Pop two from full: stall drops, then refill behind survivors.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd2, 1'b0);
    step();
    checkEq("pop_full_count", 64'(dut.countQ), 64'd6);
    checkEq("pop_full_stall", 64'(qi.stall), 64'd0);
    checkOut("pop_full", 32'h22222222, 32'h8, 32'h33333333, 32'hC);
    drive(1'b1, 32'h99999999, 32'h20, 1'b1, 32'h88888888, 32'h24, 2'd0, 1'b0);
    step();
    checkEq("refill_count", 64'(dut.countQ), 64'd8);
    checkEq("refill_stall", 64'(qi.stall), 64'd1);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd2, 1'b0);
    step();
    checkOut("drain1", 32'h44444444, 32'h10, 32'h55555555, 32'h14);
    // pop_count=3 behaves as 2.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd3, 1'b0);
    step();
    checkOut("drain2", 32'h66666666, 32'h18, 32'h77777777, 32'h1C);
    checkEq("drain2_count", 64'(dut.countQ), 64'd4);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd1, 1'b0);
    step();
    checkOut("drain3", 32'h77777777, 32'h1C, 32'h99999999, 32'h20);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd1, 1'b0);
    step();
    checkOut("drain4", 32'h99999999, 32'h20, 32'h88888888, 32'h24);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd2, 1'b0);
    step();
    checkEmpty("drained");

    // B-only push into empty queue.
    drive(1'b0, '0, '0, 1'b1, 32'h55555555, 32'h14, 2'd0, 1'b0);
    step();
    checkEq("bonly_a_valid", 64'(qi.out_a_valid), 64'd1);
    checkEq("bonly_a_instr", 64'(qi.out_a_instr), 64'h55555555);
    checkEq("bonly_a_addr",  64'(qi.out_a_addr),  64'h14);
    checkEq("bonly_b_valid", 64'(qi.out_b_valid), 64'd0);
    checkEq("bonly_count",   64'(dut.countQ),     64'd1);
    // Over-pop is clamped to the single entry.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd3, 1'b0);
    step();
    checkEmpty("clamp");

    // Wrap-around: 20 pairs streamed with pop 2 every cycle.
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 32'hC0000000 + 32'(2 * j), 32'h100 + 32'(8 * j),
            1'b1, 32'hC0000001 + 32'(2 * j), 32'h104 + 32'(8 * j), 2'd2, 1'b0);
      step();
      checkOut($sformatf("wrap%0d", j), 32'hC0000000 + 32'(2 * j), 32'h100 + 32'(8 * j),
               32'hC0000001 + 32'(2 * j), 32'h104 + 32'(8 * j));
      checkEq($sformatf("wrap%0d_count", j), 64'(dut.countQ), 64'd2);
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0, 2'd2, 1'b0);
    step();
    checkEmpty("wrap_end");

    // Build count=5, then flush with simultaneous push and pop.
    drive(1'b1, 32'hD0000000, 32'h200, 1'b1, 32'hD0000001, 32'h204, 2'd0, 1'b0);
    step();
    drive(1'b1, 32'hD0000002, 32'h208, 1'b1, 32'hD0000003, 32'h20C, 2'd0, 1'b0);
    step();
    drive(1'b1, 32'hD0000004, 32'h210, 1'b0, '0, '0, 2'd0, 1'b0);
    step();
    checkEq("preflush_count", 64'(dut.countQ), 64'd5);
    drive(1'b1, 32'hEEEEEEEE, 32'h300, 1'b1, 32'hEEEEEEEF, 32'h304, 2'd2, 1'b1);
    step();
    checkEmpty("flush");
    drive(1'b1, 32'h77777777, 32'h40, 1'b1, 32'h12345678, 32'h44, 2'd0, 1'b0);
    step();
    checkOut("postflush", 32'h77777777, 32'h40, 32'h12345678, 32'h44);
    checkEq("postflush_count", 64'(dut.countQ), 64'd2);

    // Reset mid-operation wins over a concurrent push.
    drive(1'b1, 32'hF0000000, 32'h500, 1'b1, 32'hF0000001, 32'h504, 2'd0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    checkEmpty("midreset");
    drive(1'b1, 32'hA5A5A5A5, 32'h600, 1'b1, 32'h5A5A5A5A, 32'h604, 2'd0, 1'b0);
    step();
    checkOut("postreset", 32'hA5A5A5A5, 32'h600, 32'h5A5A5A5A, 32'h604);
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
